bike_decoder_loop_ctrl: RTL and testbench

//  Sequences the BIKE decoder's nested loop: an outer iteration count and an inner block index.
//  The inner index counts down and wraps to BLOCKS-1.

---
 rtl/bike_loop_pkg.sv | 18 +
 rtl/bike_countdown_ld.sv | 42 ++++
 rtl/bike_decoder_loop_ctrl.sv | 145 ++++++++++++++
 tb/tb_bike_decoder_loop_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bike_loop_pkg.sv
// Shared types and helpers for the BIKE decoder loop controller.
// Provides the loop FSM state encoding and an index-width helper.
package bike_loop_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } loop_state_t;

   // Bits needed to hold n-1, never less than one.
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/bike_countdown_ld.sv
// Loadable down-counter for the inner block index of the BIKE loop.
// Ports: clk, resetn (sync, active-low), load, en -> cnt, is_zero.
module bike_countdown_ld #(
   parameter int BLOCKS = 12,
   parameter int BLK_W  = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic             en,
   output logic [BLK_W-1:0] cnt,
   output logic             is_zero
);

   localparam logic [BLK_W-1:0] TOP = BLK_W'(BLOCKS - 1);
   localparam logic [BLK_W-1:0] ONE = BLK_W'(1);

   logic [BLK_W-1:0] cnt_q;
   logic [BLK_W-1:0] cnt_d;

   assign is_zero = (cnt_q == '0);
   assign cnt     = cnt_q;

   // Load beats enable; an enabled count at zero wraps to the top.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = TOP;
      end else if (en) begin
         cnt_d = is_zero ? TOP : (cnt_q - ONE);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= TOP;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bike_decoder_loop_ctrl.sv
// BIKE decoder loop sequencer: outer iteration count, inner block countdown.
// Ports: clk, resetn, start, abort, step_ready -> step_valid, iter_idx,
//   blk_idx, first_blk, last_blk, busy, done.
// Optional BIKE_LOOP_CTRL_EARLY_EXIT_EN adds syndrome_zero in, early_exit out.
module bike_decoder_loop_ctrl
   import bike_loop_pkg::*;
#(
   parameter int ITER_MAX = 5,
   parameter int BLOCKS   = 12,
   parameter int ITER_W   = clog2_min1(ITER_MAX),
   parameter int BLK_W    = clog2_min1(BLOCKS)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic              step_ready,
`ifdef BIKE_LOOP_CTRL_EARLY_EXIT_EN
   input  logic              syndrome_zero,
   output logic              early_exit,
`endif
   output logic              step_valid,
   output logic [ITER_W-1:0] iter_idx,
   output logic [BLK_W-1:0]  blk_idx,
   output logic              first_blk,
   output logic              last_blk,
   output logic              busy,
   output logic              done
);

   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER_MAX - 1);
   localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
   localparam logic [BLK_W-1:0]  BLK_TOP   = BLK_W'(BLOCKS - 1);

   loop_state_t       state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              blk_zero;
   logic              xfer;
   logic              blk_load;
   logic              blk_en;
   logic              exit_now;
   logic              early_now;

   assign step_valid = (state_q == RUN);
   assign xfer       = step_valid & step_ready;
   assign busy       = (state_q != IDLE);
   assign iter_idx   = iter_q;
   assign first_blk  = step_valid & (blk_idx == BLK_TOP);
   assign last_blk   = step_valid & blk_zero;

   // Counter only moves on an un-aborted transfer; elsewhere held at top.
   assign blk_load = abort | (state_q != RUN);
   assign blk_en   = xfer & ~abort;

   bike_countdown_ld #(
      .BLOCKS (BLOCKS),
      .BLK_W  (BLK_W)
   ) u_blk (
      .clk     (clk),
      .resetn  (resetn),
      .load    (blk_load),
      .en      (blk_en),
      .cnt     (blk_idx),
      .is_zero (blk_zero)
   );

`ifdef BIKE_LOOP_CTRL_EARLY_EXIT_EN
   logic early_q, early_d;
   // Only an exit before the final iteration counts as early.
   assign early_now = syndrome_zero & (iter_q != ITER_LAST);
   assign exit_now  = syndrome_zero | (iter_q == ITER_LAST);
`else
   assign early_now = 1'b0;
   assign exit_now  = (iter_q == ITER_LAST);
`endif

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      unique case (state_q)
         IDLE: begin
            iter_d = '0;
            if (start && !abort) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               iter_d  = '0;
            end else if (xfer && blk_zero) begin
               if (exit_now) begin
                  state_d = DONE;
               end else begin
                  iter_d = iter_q + ITER_ONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            iter_d  = '0;
         end
         default: begin
            state_d = IDLE;
            iter_d  = '0;
         end
      endcase
   end

   // An abort landing on the DONE cycle suppresses the pulse.
   assign done = (state_q == DONE) & ~abort;

`ifdef BIKE_LOOP_CTRL_EARLY_EXIT_EN
   always_comb begin
      early_d = 1'b0;
      if (state_q == RUN && !abort && xfer && blk_zero) begin
         early_d = early_now;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         early_q <= 1'b0;
      end else begin
         early_q <= early_d;
      end
   end

   assign early_exit = done & early_q;
`else
   logic unused_early;
   assign unused_early = early_now;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
      end
   end

endmodule

// File: tb/tb_bike_decoder_loop_ctrl.sv
// Directed bench for bike_decoder_loop_ctrl (BLOCKS=3/ITER_MAX=2 and 1/1).
// Early-exit scenario runs when BIKE_LOOP_CTRL_EARLY_EXIT_EN is defined.
module tb_bike_decoder_loop_ctrl;

   logic clk = 1'b0;
   logic resetn;
   logic abort;
   logic step_ready;
   logic syn_zero;
   logic start_a, start_b, start_c;

   logic       sv_a, first_a, last_a, busy_a, done_a;
   logic [0:0] iter_a;
   logic [1:0] blk_a;
   logic       sv_b, first_b, last_b, busy_b, done_b;
   logic [0:0] iter_b;
   logic [0:0] blk_b;
   logic       sv_c, first_c, last_c, busy_c, done_c;
   logic [2:0] iter_c;
   logic [1:0] blk_c;
   logic       ee_a, ee_b, ee_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bike_decoder_loop_ctrl #(
      .ITER_MAX (2), .BLOCKS (3), .ITER_W (1), .BLK_W (2)
   ) u_a (
      .clk (clk), .resetn (resetn), .start (start_a),
      .abort (abort), .step_ready (step_ready),
`ifdef BIKE_LOOP_CTRL_EARLY_EXIT_EN
      .syndrome_zero (1'b0), .early_exit (ee_a),
`endif
      .step_valid (sv_a), .iter_idx (iter_a), .blk_idx (blk_a),
      .first_blk (first_a), .last_blk (last_a),
      .busy (busy_a), .done (done_a)
   );

   bike_decoder_loop_ctrl #(
      .ITER_MAX (1), .BLOCKS (1), .ITER_W (1), .BLK_W (1)
   ) u_b (
      .clk (clk), .resetn (resetn), .start (start_b),
      .abort (abort), .step_ready (step_ready),
`ifdef BIKE_LOOP_CTRL_EARLY_EXIT_EN
      .syndrome_zero (1'b0), .early_exit (ee_b),
`endif
      .step_valid (sv_b), .iter_idx (iter_b), .blk_idx (blk_b),
      .first_blk (first_b), .last_blk (last_b),
      .busy (busy_b), .done (done_b)
   );

   bike_decoder_loop_ctrl #(
      .ITER_MAX (5), .BLOCKS (3), .ITER_W (3), .BLK_W (2)
   ) u_c (
      .clk (clk), .resetn (resetn), .start (start_c),
      .abort (abort), .step_ready (step_ready),
`ifdef BIKE_LOOP_CTRL_EARLY_EXIT_EN
      .syndrome_zero (syn_zero), .early_exit (ee_c),
`endif
      .step_valid (sv_c), .iter_idx (iter_c), .blk_idx (blk_c),
      .first_blk (first_c), .last_blk (last_c),
      .busy (busy_c), .done (done_c)
   );

   // Observation vector for instance A:
   // {step_valid, iter, blk[1:0], first, last, busy, done}
   function automatic logic [7:0] obs_a();
      return {sv_a, iter_a, blk_a, first_a, last_a, busy_a, done_a};
   endfunction

   function automatic logic [7:0] step_exp(input int it, input int bk);
      logic [7:0] e;
      e[7]   = 1'b1;
      e[6]   = (it == 1);
      e[5:4] = 2'(bk);
      e[3]   = (bk == 2);
      e[2]   = (bk == 0);
      e[1]   = 1'b1;
      e[0]   = 1'b0;
      return e;
   endfunction

   localparam logic [7:0] IDLE_EXP = 8'b0_0_10_0_0_0_0;

   int seq_it [6] = '{0, 0, 0, 1, 1, 1};
   int seq_bk [6] = '{2, 1, 0, 2, 1, 0};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      checks++;
      if (obs_a() !== IDLE_EXP) begin
         errors++;
         $display("FAIL reset_a: got %b expected %b", obs_a(), IDLE_EXP);
      end
      checks++;
      if ({sv_b, busy_b, done_b} !== 3'b000) begin
         errors++;
         $display("FAIL reset_b: got %b expected 000",
                  {sv_b, busy_b, done_b});
      end
   endtask

   task automatic test_sequence();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (obs_a() !== step_exp(seq_it[i], seq_bk[i])) begin
            errors++;
            $display("FAIL seq_step%0d: got %b expected %b", i,
                     obs_a(), step_exp(seq_it[i], seq_bk[i]));
         end
         tick();
      end
      checks++;
      if ({sv_a, busy_a, done_a} !== 3'b011) begin
         errors++;
         $display("FAIL seq_done: got %b expected 011",
                  {sv_a, busy_a, done_a});
      end
      tick();
      checks++;
      if (obs_a() !== IDLE_EXP) begin
         errors++;
         $display("FAIL seq_idle: got %b expected %b", obs_a(), IDLE_EXP);
      end
   endtask

   task automatic test_stall();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      step_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs_a() !== step_exp(0, 1)) begin
            errors++;
            $display("FAIL stall_hold%0d: got %b expected %b", i,
                     obs_a(), step_exp(0, 1));
         end
         tick();
      end
      step_ready = 1'b1;
      for (int i = 1; i < 6; i++) begin
         checks++;
         if (obs_a() !== step_exp(seq_it[i], seq_bk[i])) begin
            errors++;
            $display("FAIL stall_step%0d: got %b expected %b", i,
                     obs_a(), step_exp(seq_it[i], seq_bk[i]));
         end
         tick();
      end
      checks++;
      if ({sv_a, busy_a, done_a} !== 3'b011) begin
         errors++;
         $display("FAIL stall_done: got %b expected 011",
                  {sv_a, busy_a, done_a});
      end
      tick();
   endtask

   task automatic test_abort();
      int dn;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (4) tick();
      checks++;
      if (obs_a() !== step_exp(1, 1)) begin
         errors++;
         $display("FAIL abort_pre: got %b expected %b",
                  obs_a(), step_exp(1, 1));
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (obs_a() !== IDLE_EXP) begin
         errors++;
         $display("FAIL abort_idle: got %b expected %b", obs_a(), IDLE_EXP);
      end
      dn = 0;
      repeat (4) begin
         tick();
         if (done_a) dn++;
      end
      checks++;
      if (dn !== 0) begin
         errors++;
         $display("FAIL abort_nodone: got %0d expected 0", dn);
      end
   endtask

   task automatic test_start_ignored();
      int dn;
      dn = 0;
      for (int c = 0; c < 20; c++) begin
         start_a = (c == 0) || (c == 3) || done_a;
         tick();
         start_a = 1'b0;
         if (done_a) dn++;
      end
      checks++;
      if (dn !== 1) begin
         errors++;
         $display("FAIL start_ign_count: got %0d expected 1", dn);
      end
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL start_ign_busy: got %b expected 0", busy_a);
      end
   endtask

   task automatic test_blocks1();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      checks++;
      if ({sv_b, iter_b, blk_b, first_b, last_b, done_b} !== 6'b100110) begin
         errors++;
         $display("FAIL b1_step: got %b expected 100110",
                  {sv_b, iter_b, blk_b, first_b, last_b, done_b});
      end
      tick();
      checks++;
      if ({sv_b, busy_b, done_b} !== 3'b011) begin
         errors++;
         $display("FAIL b1_done: got %b expected 011",
                  {sv_b, busy_b, done_b});
      end
      tick();
      checks++;
      if ({busy_b, done_b} !== 2'b00) begin
         errors++;
         $display("FAIL b1_idle: got %b expected 00", {busy_b, done_b});
      end
   endtask

`ifdef BIKE_LOOP_CTRL_EARLY_EXIT_EN
   task automatic test_early_exit();
      int max_it;
      max_it = 0;
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      repeat (5) begin
         if (int'(iter_c) > max_it) max_it = int'(iter_c);
         tick();
      end
      checks++;
      if ({sv_c, iter_c, blk_c} !== 6'b1_001_00) begin
         errors++;
         $display("FAIL early_pre: got %b expected 100100",
                  {sv_c, iter_c, blk_c});
      end
      syn_zero = 1'b1;
      tick();
      syn_zero = 1'b0;
      checks++;
      if ({sv_c, done_c, ee_c} !== 3'b011) begin
         errors++;
         $display("FAIL early_done: got %b expected 011",
                  {sv_c, done_c, ee_c});
      end
      tick();
      checks++;
      if ({busy_c, done_c, ee_c} !== 3'b000) begin
         errors++;
         $display("FAIL early_idle: got %b expected 000",
                  {busy_c, done_c, ee_c});
      end
      checks++;
      if (max_it >= 2 || int'(iter_c) >= 2) begin
         errors++;
         $display("FAIL early_iter: got %0d expected <2", max_it);
      end
   endtask
`endif

   task automatic test_reset_mid();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (2) tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      checks++;
      if (obs_a() !== IDLE_EXP) begin
         errors++;
         $display("FAIL rst_mid: got %b expected %b", obs_a(), IDLE_EXP);
      end
      tick();
      checks++;
      if (done_a !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_nodone: got %b expected 0", done_a);
      end
      test_sequence();
   endtask

   initial begin
      resetn     = 1'b0;
      abort      = 1'b0;
      step_ready = 1'b1;
      syn_zero   = 1'b0;
      start_a    = 1'b0;
      start_b    = 1'b0;
      start_c    = 1'b0;
      #1;
      test_reset();
      test_sequence();
      test_stall();
      test_abort();
      test_start_ignored();
      test_blocks1();
`ifdef BIKE_LOOP_CTRL_EARLY_EXIT_EN
      test_early_exit();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
